// File: rtl/fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, issues sequential imem reads and buffers
// {pc, instr} pairs for decode. Optional macro FETCH_BYPASS_EN adds a same-cycle resp->deq path.
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h6000_0000
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [31:0]              imem_address,
    output logic                     imem_read,
    input  logic [31:0]              imem_rdata,
    input  logic                     imem_resp,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    output logic [31:0]              deq_instr,
    output logic [31:0]              deq_pc,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inflight_q, inflight_d;
    logic [31:0]   addr_q, addr_d;
    logic          read_q, read_d;
    logic [PW:0]   count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [31:0]   instr_q [DEPTH];
    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   redirect_aligned;
    logic          bypass, accept, push, pop;

`ifdef FETCH_BYPASS_EN
    assign bypass    = (count_q == '0) && (state_q == FETCH) && imem_resp && !redirect;
    assign deq_valid = (count_q != '0) || bypass;
    assign deq_instr = bypass ? imem_rdata : instr_q[rd_ptr_q];
    assign deq_pc    = bypass ? fetch_pc_q : pc_q[rd_ptr_q];
`else
    assign bypass    = 1'b0;
    assign deq_valid = (count_q != '0);
    assign deq_instr = instr_q[rd_ptr_q];
    assign deq_pc    = pc_q[rd_ptr_q];
`endif

    assign imem_address = addr_q;
    assign imem_read    = read_q;
    assign count        = count_q;

    always_comb begin
        redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
        accept = (state_q == FETCH) && imem_resp && !redirect;
        // A bypassed word taken by the consumer never occupies an entry.
        push   = accept && !(bypass && deq_ready);
        pop    = (count_q != '0) && deq_ready;

        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
            rd_ptr_d = rd_ptr_q + PW'(pop);
            wr_ptr_d = wr_ptr_q + PW'(push);
        end

        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        case (state_q)
            IDLE: begin
                if (redirect) begin
                    fetch_pc_d = redirect_aligned;
                    state_d    = FETCH;
                end else if (count_q < FULL) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (imem_resp) begin
                    if (redirect) begin
                        fetch_pc_d = redirect_aligned;
                    end else begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = (count_d < FULL) ? FETCH : IDLE;
                    end
                end else if (redirect) begin
                    inflight_d = fetch_pc_q;
                    fetch_pc_d = redirect_aligned;
                    state_d    = DISCARD;
                end
            end
            DISCARD: begin
                if (redirect) fetch_pc_d = redirect_aligned;
                if (imem_resp) state_d = FETCH;
            end
            default: state_d = IDLE;
        endcase

        // The stale request keeps its address on the bus until it completes.
        addr_d = (state_d == DISCARD) ? inflight_d : fetch_pc_d;
        read_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            inflight_q <= RESET_PC;
            addr_q     <= RESET_PC;
            read_q     <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            addr_q     <= addr_d;
            read_q     <= read_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            if (push) begin
                instr_q[wr_ptr_q] <= imem_rdata;
                pc_q[wr_ptr_q]    <= fetch_pc_q;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: queue-level reference model checked every cycle plus directed scenarios.
module tb_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h6000_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_address, imem_rdata, redirect_pc, deq_instr, deq_pc;
    logic        imem_read, imem_resp, redirect, deq_valid, deq_ready;
    logic [2:0]  count;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .imem_address(imem_address), .imem_read(imem_read),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .deq_valid(deq_valid), .deq_ready(deq_ready),
        .deq_instr(deq_instr), .deq_pc(deq_pc), .count(count)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Reference model: a queue of fetched words plus the state of the memory request.
    typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc, m_addr;
    bit          m_act, m_stale;

    always @(posedge clk or posedge rst) begin
        int   sz0;
        bit   done;
        ent_t e;
        if (rst) begin
            mq.delete();
            m_pc = RESET_PC; m_addr = RESET_PC; m_act = 0; m_stale = 0;
        end else begin
            sz0  = mq.size();
            done = m_act && imem_resp;
            if (sz0 != 0 && deq_ready) void'(mq.pop_front());
            if (done && !m_stale && !redirect) begin
                if (!(BYP && sz0 == 0 && deq_ready)) begin
                    e.pc = m_addr; e.instr = imem_rdata;
                    mq.push_back(e);
                end
                m_pc = m_pc + 32'd4;
            end
            if (redirect) begin
                mq.delete();
                m_pc = redirect_pc & 32'hFFFF_FFFC;
            end
            if (done) begin
                m_stale = 0;
                m_act   = (mq.size() < DEPTH);
                m_addr  = m_pc;
            end else if (m_act) begin
                if (redirect) m_stale = 1;
            end else if (redirect || sz0 < DEPTH) begin
                m_act  = 1;
                m_addr = m_pc;
            end
        end
    end

    always @(negedge clk) begin
        bit          ev;
        logic [31:0] ei, ep;
        ev = (mq.size() != 0);
        ei = ev ? mq[0].instr : 32'h0;
        ep = ev ? mq[0].pc : 32'h0;
        if (BYP && !rst && mq.size() == 0 && m_act && !m_stale && imem_resp && !redirect) begin
            ev = 1; ei = imem_rdata; ep = m_addr;
        end
        chk("imem_read", {31'b0, imem_read}, {31'b0, m_act});
        chk("imem_address", imem_address, m_act ? m_addr : m_pc);
        chk("count", {29'b0, count}, 32'(mq.size()));
        chk("deq_valid", {31'b0, deq_valid}, {31'b0, ev});
        if (ev) begin
            chk("deq_instr", deq_instr, ei);
            chk("deq_pc", deq_pc, ep);
        end
    end

    // Memory responder: resp after `lat` cycles of imem_read.
    bit auto_resp = 1;
    int lat = 2;
    int wcnt = 0;

    task automatic cyc();
        @(posedge clk); #1;
        redirect = 1'b0;
        if (auto_resp && imem_read) begin
            wcnt++;
            if (wcnt >= lat) begin
                imem_resp = 1'b1; imem_rdata = word_at(imem_address); wcnt = 0;
            end else imem_resp = 1'b0;
        end else begin
            imem_resp = 1'b0; wcnt = 0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; redirect = 1'b0; imem_resp = 1'b0; wcnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic wait_count(input int target, input string name);
        int n = 0;
        while (count != 3'(target) && n < 50) begin cyc(); n++; end
        chk(name, {29'b0, count}, 32'(target));
    endtask

    task automatic wait_addr(input logic [31:0] a, input string name);
        int n = 0;
        while (!(imem_read && imem_address == a) && n < 50) begin cyc(); n++; end
        chk(name, imem_address, a);
    endtask

    task automatic wait_resp(input string name);
        int n = 0;
        while (!imem_resp && n < 50) begin cyc(); n++; end
        chk(name, {31'b0, imem_resp}, 32'd1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!deq_valid && n < 50) begin cyc(); n++; end
        chk(name, {31'b0, deq_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; imem_rdata = '0; imem_resp = 1'b0; redirect = 1'b0;
        redirect_pc = '0; deq_ready = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_addr", imem_address, 32'h6000_0000);
        chk("rst_read", {31'b0, imem_read}, 32'd0);
        chk("rst_count", {29'b0, count}, 32'd0);
        chk("rst_valid", {31'b0, deq_valid}, 32'd0);
        chk("rst_instr", deq_instr, 32'd0);
        chk("rst_pc", deq_pc, 32'd0);
        rst = 1'b0;

        // Sequential fetch with an always-ready consumer
        cyc();
        chk("first_addr", imem_address, 32'h6000_0000);
        chk("first_read", {31'b0, imem_read}, 32'd1);
        cyc();
        chk("first_resp", {31'b0, imem_resp}, 32'd1);
`ifdef FETCH_BYPASS_EN
        chk("byp_valid", {31'b0, deq_valid}, 32'd1);
        chk("byp_instr", deq_instr, word_at(32'h6000_0000));
        cyc();
        chk("byp_count", {29'b0, count}, 32'd0);
`else
        chk("no_bypass_valid", {31'b0, deq_valid}, 32'd0);
        cyc();
        chk("lat1_valid", {31'b0, deq_valid}, 32'd1);
        chk("lat1_pc", deq_pc, 32'h6000_0000);
        chk("lat1_instr", deq_instr, word_at(32'h6000_0000));
        chk("next_addr", imem_address, 32'h6000_0004);
        wait_resp("resp2");
        cyc();
        chk("second_pc", deq_pc, 32'h6000_0004);
`endif
        repeat (10) cyc();

        // Fill to DEPTH, then release one entry
        do_reset();
        deq_ready = 1'b0;
        wait_count(4, "fill_count");
        chk("full_read", {31'b0, imem_read}, 32'd0);
        chk("full_head", deq_pc, 32'h6000_0000);
        cyc(); cyc();
        chk("full_hold", {31'b0, imem_read}, 32'd0);
        deq_ready = 1'b1;
        cyc();
        deq_ready = 1'b0;
        chk("pop_count", {29'b0, count}, 32'd3);
        chk("pop_read", {31'b0, imem_read}, 32'd0);
        cyc();
        chk("refetch_read", {31'b0, imem_read}, 32'd1);
        chk("refetch_addr", imem_address, 32'h6000_0010);
        chk("refetch_head", deq_pc, 32'h6000_0004);

        // Redirect while a request is outstanding
        do_reset();
        deq_ready = 1'b0; lat = 4;
        wait_addr(32'h6000_0008, "pre_redirect_addr");
        chk("pre_redirect_count", {29'b0, count}, 32'd2);
        redirect = 1'b1; redirect_pc = 32'h6000_0100;
        cyc();
        chk("flush_count", {29'b0, count}, 32'd0);
        chk("flush_valid", {31'b0, deq_valid}, 32'd0);
        chk("discard_addr1", imem_address, 32'h6000_0008);
        cyc();
        chk("discard_addr2", imem_address, 32'h6000_0008);
        cyc();
        chk("discard_resp", {31'b0, imem_resp}, 32'd1);
        chk("discard_addr3", imem_address, 32'h6000_0008);
        cyc();
        chk("post_discard_addr", imem_address, 32'h6000_0100);
        chk("post_discard_count", {29'b0, count}, 32'd0);
        deq_ready = 1'b1;
        wait_valid("redirect_valid");
        chk("redirect_head", deq_pc, 32'h6000_0100);
        lat = 2;
        repeat (4) cyc();

        // Redirect coinciding with a response
        do_reset();
        deq_ready = 1'b0;
        wait_addr(32'h6000_0004, "same_cycle_pre");
        wait_resp("same_cycle_resp");
        redirect = 1'b1; redirect_pc = 32'h6000_0203;
        cyc();
        chk("same_cycle_addr", imem_address, 32'h6000_0200);
        chk("same_cycle_read", {31'b0, imem_read}, 32'd1);
        chk("same_cycle_count", {29'b0, count}, 32'd0);
        deq_ready = 1'b1;
        wait_valid("same_cycle_valid");
        chk("same_cycle_head", deq_pc, 32'h6000_0200);
        repeat (4) cyc();

        // Reset mid-fetch, then a stale response while idle
        do_reset();
        deq_ready = 1'b0;
        wait_count(2, "pre_reset_count");
        rst = 1'b1; imem_resp = 1'b0;
        #1;
        chk("midrst_read", {31'b0, imem_read}, 32'd0);
        chk("midrst_addr", imem_address, 32'h6000_0000);
        chk("midrst_count", {29'b0, count}, 32'd0);
        chk("midrst_valid", {31'b0, deq_valid}, 32'd0);
        chk("midrst_instr", deq_instr, 32'd0);
        chk("midrst_pc", deq_pc, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; auto_resp = 0;
        imem_resp = 1'b1; imem_rdata = 32'h1234_5678;
        cyc();
        chk("stale_count", {29'b0, count}, 32'd0);
        chk("restart_read", {31'b0, imem_read}, 32'd1);
        chk("restart_addr", imem_address, 32'h6000_0000);
        auto_resp = 1; deq_ready = 1'b1;
        wait_valid("restart_valid");
        chk("restart_pc", deq_pc, 32'h6000_0000);
        chk("restart_instr", deq_instr, word_at(32'h6000_0000));
        repeat (6) cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
